// File: rtl/mux4x1_rr.sv
// mux4x1_rr -- four-channel round-robin merge into a single registered
// output stage.
//
// Each cycle, if the output register can take a word (it is empty, or its
// current word is being drained), one requesting channel is granted. The
// search starts just after the most recently granted channel, so every
// requester is served within four loads. The granted word and its channel
// index are captured one cycle later in out_data / {out_s1,out_s0}.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream: in_valid[k] & in_ready[k]. Downstream: out_valid &
// out_ready. Valid never depends on ready. At most one in_ready bit is
// high, and in_ready is combinational from in_valid, out_valid, out_ready
// and the internal last-grant pointer.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : [3:0] channel k offers d<k>
//   in_ready   : [3:0] one-hot grant, channel k word accepted this cycle
//   d0..d3     : [W-1:0] channel data words
//   out_valid  : output register holds a valid word (FULL)
//   out_ready  : downstream accepts the word this cycle
//   out_data   : [W-1:0] registered selected word
//   out_s1/s0  : registered source channel index of out_data
module mux4x1_rr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_s1,
  output logic         out_s0
);

  // Output register occupancy; out_valid is the state itself.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;

  logic [1:0]   last;       // most recently granted channel
  logic [1:0]   grant;      // winning channel this cycle
  logic         load;       // output register captures a new word
  logic [W-1:0] sel_data;   // data of the granted channel
  logic [1:0]   idx;
  logic         found;

  assign out_valid = (state == FULL);

  // Round-robin search: last+1, last+2, last+3, last (mod 4). The 2-bit
  // add wraps naturally, so the pointer itself comes last.
  always_comb begin
    grant = last;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i < 5; i++) begin
      idx = last + i[1:0];
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Reset blocks the load so no word is taken while the stage is cleared.
  assign load = (~out_valid | out_ready) & (|in_valid) & ~rst;

  always_comb begin
    in_ready = 4'b0000;
    if (load) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    sel_data = d0;
    case (grant)
      2'd0:    sel_data = d0;
      2'd1:    sel_data = d1;
      2'd2:    sel_data = d2;
      default: sel_data = d3;
    endcase
  end

  // Next occupancy: a load always leaves the register full (this covers a
  // simultaneous drain and refill); a drain without a load empties it.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (load) state_next = FULL;
      end
      FULL: begin
        if (load)           state_next = FULL;
        else if (out_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_s1   <= 1'b0;
      out_s0   <= 1'b0;
      last     <= 2'd3;  // channel 0 is searched first after reset
    end else begin
      state <= state_next;
      if (load) begin
        out_data <= sel_data;
        out_s1   <= grant[1];
        out_s0   <= grant[0];
        last     <= grant;
      end
    end
  end

endmodule
